countdown_secs_timer: RTL and testbench

Loadable down-counting seconds timer with a start/pause/done state machine. It counts a preset number of seconds (1..MAX_SECS) down to zero at a 1 Hz rate derived from the system clock. It sits beside the up-counting seconds counter in the driver set and feeds FSM drivers that need a timeout or countdown display value.

---
 rtl/countdown_pkg.sv | 18 +
 rtl/sec_prescaler.sv | 44 ++++
 rtl/countdown_secs_timer.sv | 151 +++++++++++++++
 tb/tb_countdown_secs_timer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// countdown_pkg
// Shared types and default constants for the countdown seconds timer.
//   state_e            : FSM state encoding (IDLE=0, RUN=1, PAUSED=2, DONE=3)
//   CLK_FREQ_DEFAULT   : default clock cycles per second
//   MAX_SECS_DEFAULT   : default largest loadable seconds value
package countdown_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam int CLK_FREQ_DEFAULT = 50000000;
   localparam int MAX_SECS_DEFAULT = 90;

endpackage

// File: rtl/sec_prescaler.sv
// sec_prescaler
// Divides the system clock down to a once-per-second strobe.
// The counter advances only while enabled, so a held value survives a pause.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enable     : advance the counter this cycle
//   clear      : force the counter to 0 (wins over enable)
//   wrap       : one-cycle strobe, high in the cycle the counter wraps
module sec_prescaler #(
   parameter int CLK_FREQ = 50000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic clear,
   output logic wrap
);

   localparam int PW_RAW = $clog2(CLK_FREQ);
   localparam int PW     = (PW_RAW > 0) ? PW_RAW : 1;
   localparam logic [PW-1:0] TC = PW'(CLK_FREQ - 1);

   logic [PW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable) begin
         cnt_d = (cnt_q == TC) ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign wrap = enable && !clear && (cnt_q == TC);

endmodule

// File: rtl/countdown_secs_timer.sv
// countdown_secs_timer
// Loadable down-counting seconds timer with IDLE/RUN/PAUSED/DONE control.
// Optional build macro: COUNTDOWN_AUTO_RELOAD_EN -- when defined, reaching
// zero in RUN reloads the count from the reload register and keeps running.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (saturated to MAX_SECS), go to IDLE
//   load_val   : preset seconds value
//   start      : start from IDLE or resume from PAUSED
//   pause      : freeze the countdown while in RUN
//   sec_count  : remaining seconds (registered)
//   tick       : one-cycle pulse on each decrement
//   expired    : one-cycle pulse when the count reaches 0
//   running    : high while in RUN
//   done       : high while in DONE
module countdown_secs_timer
   import countdown_pkg::*;
#(
   parameter int CLK_FREQ = CLK_FREQ_DEFAULT,
   parameter int MAX_SECS = MAX_SECS_DEFAULT,
   parameter int CNT_W    = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   output logic [CNT_W-1:0] sec_count,
   output logic             tick,
   output logic             expired,
   output logic             running,
   output logic             done
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_SECS);

   function automatic logic [CNT_W-1:0] sat_secs(input logic [CNT_W-1:0] v);
      return (v > MAX_C) ? MAX_C : v;
   endfunction

   state_e           state_q, state_d;
   logic [CNT_W-1:0] sec_count_q, sec_count_d;
   logic [CNT_W-1:0] reload_q, reload_d;
   logic             tick_q, tick_d;
   logic             expired_q, expired_d;
   logic             running_q, running_d;
   logic             done_q, done_d;

   logic             presc_en, presc_clr, presc_wrap;

   // Prescaler control is derived straight from state and inputs so that the
   // wrap strobe feeding the FSM has no path back into its own enable.
   assign presc_en  = (state_q == ST_RUN) && !pause && !load;
   assign presc_clr = load || ((state_q == ST_IDLE) && start && (sec_count_q != '0));

   sec_prescaler #(.CLK_FREQ(CLK_FREQ)) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .enable (presc_en),
      .clear  (presc_clr),
      .wrap   (presc_wrap)
   );

   always_comb begin
      state_d     = state_q;
      sec_count_d = sec_count_q;
      reload_d    = reload_q;
      tick_d      = 1'b0;
      expired_d   = 1'b0;

      if (load) begin
         sec_count_d = sat_secs(load_val);
         reload_d    = sat_secs(load_val);
         state_d     = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && (sec_count_q != '0)) begin
                  state_d = ST_RUN;
               end
            end
            ST_RUN: begin
               if (pause) begin
                  state_d = ST_PAUSED;
               end else if (presc_wrap) begin
                  tick_d = 1'b1;
                  // In RUN the count is always >= 1, so 1 means this tick hits zero.
                  if (sec_count_q == CNT_W'(1)) begin
                     expired_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                     if (reload_q != '0) begin
                        sec_count_d = reload_q;
                     end else begin
                        sec_count_d = '0;
                        state_d     = ST_DONE;
                     end
`else
                     sec_count_d = '0;
                     state_d     = ST_DONE;
`endif
                  end else begin
                     sec_count_d = sec_count_q - 1'b1;
                  end
               end
            end
            ST_PAUSED: begin
               if (start) begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: begin
               sec_count_d = '0;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      running_d = (state_d == ST_RUN);
      done_d    = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         sec_count_q <= '0;
         reload_q    <= '0;
         tick_q      <= 1'b0;
         expired_q   <= 1'b0;
         running_q   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sec_count_q <= sec_count_d;
         reload_q    <= reload_d;
         tick_q      <= tick_d;
         expired_q   <= expired_d;
         running_q   <= running_d;
         done_q      <= done_d;
      end
   end

   assign sec_count = sec_count_q;
   assign tick      = tick_q;
   assign expired   = expired_q;
   assign running   = running_q;
   assign done      = done_q;

endmodule

// File: tb/tb_countdown_secs_timer.sv
// tb_countdown_secs_timer
// Directed bench for countdown_secs_timer with CLK_FREQ = 4.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_countdown_secs_timer;

   localparam int CLK_FREQ = 4;
   localparam int MAX_SECS = 90;
   localparam int CNT_W    = 7;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             load;
   logic [CNT_W-1:0] load_val;
   logic             start;
   logic             pause;
   logic [CNT_W-1:0] sec_count;
   logic             tick;
   logic             expired;
   logic             running;
   logic             done;

   int n_checks = 0;
   int n_errors = 0;

   countdown_secs_timer #(
      .CLK_FREQ (CLK_FREQ),
      .MAX_SECS (MAX_SECS),
      .CNT_W    (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_val  (load_val),
      .start     (start),
      .pause     (pause),
      .sec_count (sec_count),
      .tick      (tick),
      .expired   (expired),
      .running   (running),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [CNT_W-1:0] v);
      load     = 1'b1;
      load_val = v;
      cycle();
      load     = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_sec"},     32'(sec_count), 32'd0);
      check_eq({tag, "_tick"},    32'(tick),      32'd0);
      check_eq({tag, "_expired"}, 32'(expired),   32'd0);
      check_eq({tag, "_running"}, 32'(running),   32'd0);
      check_eq({tag, "_done"},    32'(done),      32'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      load     = 1'b0;
      load_val = '0;
      start    = 1'b0;
      pause    = 1'b0;
      cycle();
      cycle();
      check_all_zero("reset");
      rst_n = 1'b1;
      cycle();

      // Reset mid-RUN: sec_count = 5, prescaler = 2
      do_load(7'd5);
      do_start();
      check_eq("midrun_running", 32'(running), 32'd1);
      cycle();
      cycle();
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      cycle();
      rst_n = 1'b1;
      cycle();
      cycle();
      check_all_zero("post_rst");
      do_start();
      check_eq("post_rst_start_ignored", 32'(running), 32'd0);

      // One-shot countdown from 3
      do_load(7'd3);
      check_eq("load3_sec", 32'(sec_count), 32'd3);
      check_eq("load3_running", 32'(running), 32'd0);
      do_start();
      check_eq("run_running", 32'(running), 32'd1);
      for (int k = 1; k <= 12; k++) begin
         cycle();
         check_eq($sformatf("run_tick_%0d", k), 32'(tick), (k % 4 == 0) ? 32'd1 : 32'd0);
         check_eq($sformatf("run_expired_%0d", k), 32'(expired), (k == 12) ? 32'd1 : 32'd0);
         if (k % 4 == 0) begin
            check_eq($sformatf("run_sec_%0d", k), 32'(sec_count), 32'(3 - k / 4));
         end
      end
      check_eq("final_done", 32'(done), 32'd1);
      check_eq("final_running", 32'(running), 32'd0);
      cycle();
      check_eq("post_expire_tick", 32'(tick), 32'd0);
      check_eq("post_expire_expired", 32'(expired), 32'd0);
      do_start();
      check_eq("done_start_ignored_done", 32'(done), 32'd1);
      check_eq("done_start_ignored_running", 32'(running), 32'd0);
      check_eq("done_start_ignored_sec", 32'(sec_count), 32'd0);

      // Pause and resume keeps the partial second
      do_load(7'd3);
      check_eq("load_from_done", 32'(done), 32'd0);
      do_start();
      cycle();
      cycle();
      pause = 1'b1;
      cycle();
      pause = 1'b0;
      check_eq("paused_running", 32'(running), 32'd0);
      for (int k = 0; k < 10; k++) begin
         cycle();
         check_eq($sformatf("paused_tick_%0d", k), 32'(tick), 32'd0);
      end
      check_eq("paused_sec", 32'(sec_count), 32'd3);
      do_start();
      check_eq("resume_running", 32'(running), 32'd1);
      cycle();
      check_eq("resume_tick1", 32'(tick), 32'd0);
      cycle();
      check_eq("resume_tick2", 32'(tick), 32'd1);
      check_eq("resume_sec", 32'(sec_count), 32'd2);

      // Saturation and zero load
      do_load(7'd120);
      check_eq("sat_sec", 32'(sec_count), 32'd90);
      check_eq("sat_running", 32'(running), 32'd0);
      do_load(7'd0);
      check_eq("zero_sec", 32'(sec_count), 32'd0);
      do_start();
      check_eq("zero_start_running", 32'(running), 32'd0);
      for (int k = 0; k < 6; k++) begin
         cycle();
         check_eq($sformatf("zero_tick_%0d", k), 32'(tick), 32'd0);
      end

      // load and start together while in RUN
      do_load(7'd5);
      do_start();
      cycle();
      cycle();
      load     = 1'b1;
      load_val = 7'd7;
      start    = 1'b1;
      cycle();
      load  = 1'b0;
      start = 1'b0;
      check_eq("ld_st_sec", 32'(sec_count), 32'd7);
      check_eq("ld_st_running", 32'(running), 32'd0);
      for (int k = 0; k < 5; k++) begin
         cycle();
         check_eq($sformatf("ld_st_tick_%0d", k), 32'(tick), 32'd0);
      end

`ifdef COUNTDOWN_AUTO_RELOAD_EN
      // Auto reload keeps running through zero
      do_load(7'd2);
      do_start();
      for (int k = 1; k <= 12; k++) begin
         cycle();
         check_eq($sformatf("ar_tick_%0d", k), 32'(tick), (k % 4 == 0) ? 32'd1 : 32'd0);
         check_eq($sformatf("ar_expired_%0d", k), 32'(expired), (k == 8) ? 32'd1 : 32'd0);
         check_eq($sformatf("ar_running_%0d", k), 32'(running), 32'd1);
         check_eq($sformatf("ar_done_%0d", k), 32'(done), 32'd0);
         if (k == 4)  check_eq("ar_sec_4",  32'(sec_count), 32'd1);
         if (k == 8)  check_eq("ar_sec_8",  32'(sec_count), 32'd2);
         if (k == 12) check_eq("ar_sec_12", 32'(sec_count), 32'd1);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
